// File: rtl/booth_mult_sequencer.sv
// Iterative signed radix-4 Booth multiplier with valid/ready handshakes.
// One Booth digit is retired per clock through a shared add/shift datapath;
// one operation is held in flight at a time.
module booth_mult_sequencer #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     op1,
  input  logic [N-1:0]     op2,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             busy
);

  localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N / 2 - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_a;      // latched multiplicand
  logic [N+1:0]  r_hi;     // running upper partial sum, two guard bits
  logic [N-1:0]  r_lo;     // unconsumed multiplier bits / low product bits
  logic          r_prev;   // multiplier bit below the current digit

  logic [N+1:0]  w_a_ext;
  logic [N+1:0]  w_2a;
  logic [N+1:0]  w_pp;
  logic [N+1:0]  w_sum;
  logic          w_accept;

  assign w_a_ext = {{2{r_a[N-1]}}, r_a};
  assign w_2a    = {w_a_ext[N:0], 1'b0};
  assign w_sum   = r_hi + w_pp;

  // Booth digit decode: select the partial product for {q1,q0,prev}
  always_comb begin
    w_pp = '0;
    case ({r_lo[1:0], r_prev})
      3'b001, 3'b010: w_pp = w_a_ext;
      3'b011:         w_pp = w_2a;
      3'b100:         w_pp = ~w_2a + (N + 2)'(1);
      3'b101, 3'b110: w_pp = ~w_a_ext + (N + 2)'(1);
      default:        w_pp = '0;
    endcase
  end

  // Handshake and status outputs derived from the current state
  always_comb begin
    // In DONE a same-edge abort wins, so no new operands are claimed then.
    in_ready  = rst_n & ((r_state == S_IDLE) |
                         ((r_state == S_DONE) & out_ready & ~abort));
    w_accept  = in_valid & in_ready;
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN);
    product   = {r_hi[N-1:0], r_lo};
  end

  // Sequencer: load on accept, shift-add one digit per RUN cycle, hold in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prev  <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_a     <= op1;
      r_lo    <= op2;
      r_hi    <= '0;
      r_prev  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_hi   <= {w_sum[N+1], w_sum[N+1], w_sum[N+1:2]};
            r_lo   <= {w_sum[1:0], r_lo[N-1:2]};
            r_prev <= r_lo[1];
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST_DIGIT) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort || out_ready) r_state <= S_IDLE;
        end
        S_IDLE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer at N=8, 16 and 32 with a product scoreboard.
module tb_booth_mult_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic iv8, ir8, ab8, ov8, ordy8, bz8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic iv16, ir16, ab16, ov16, ordy16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic iv32, ir32, ab32, ov32, ordy32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  booth_mult_sequencer #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op1(a8), .op2(b8),
    .abort(ab8), .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(bz8));
  booth_mult_sequencer #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op1(a16), .op2(b16),
    .abort(ab16), .out_valid(ov16), .out_ready(ordy16), .product(p16), .busy(bz16));
  booth_mult_sequencer #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op1(a32), .op2(b32),
    .abort(ab32), .out_valid(ov32), .out_ready(ordy32), .product(p32), .busy(bz32));

  // reference models
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = $signed(a); sb = $signed(b);
    return sa * sb;
  endfunction
  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed(a); sb = $signed(b);
    return sa * sb;
  endfunction
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a); sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction
  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // scoreboards: push the model result on accept, pop and compare on output handshake
  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [63:0] q32[$];
  logic [63:0] got32[$];
  logic [15:0] e8;
  logic [31:0] e16;
  logic [63:0] e32;
  int hs8 = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ov8 && ordy8) begin
        hs8++; n_checks++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL sb8_unexpected product=%h expected=none", p8);
        end else begin
          e8 = q8.pop_front();
          if (p8 !== e8) begin n_fail++; $display("FAIL sb8_product got=%h exp=%h", p8, e8); end
        end
      end
      if (iv8 && ir8) q8.push_back(ref8(a8, b8));
      if (ov16 && ordy16) begin
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL sb16_unexpected product=%h expected=none", p16);
        end else begin
          e16 = q16.pop_front();
          if (p16 !== e16) begin n_fail++; $display("FAIL sb16_product got=%h exp=%h", p16, e16); end
        end
      end
      if (iv16 && ir16) q16.push_back(ref16(a16, b16));
      if (ov32 && ordy32) begin
        n_checks++;
        got32.push_back(p32);
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL sb32_unexpected product=%h expected=none", p32);
        end else begin
          e32 = q32.pop_front();
          if (p32 !== e32) begin n_fail++; $display("FAIL sb32_product got=%h exp=%h", p32, e32); end
        end
      end
      if (iv32 && ir32) q32.push_back(ref32(a32, b32));
    end
  end

  task automatic wait_ov8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ov8) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic abrt,
                      output logic [15:0] got);
    bit ok;
    @(posedge clk); #1;
    a8 = a; b8 = b; iv8 = 1'b1; ab8 = abrt; ordy8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0; ab8 = 1'b0;
    wait_ov8(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL run8_timeout out_valid=%b exp=1", ov8); end
    got = p8;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {iv8, ab8, ordy8, iv16, ab16, ordy16, iv32, ab32, ordy32} = '0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", ir8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov8); end
    n_checks++; if (bz8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bz8); end
    n_checks++; if (p8 !== 16'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", p8); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", ir8); end
  endtask

  task automatic test_basic();
    int lat;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd7; b8 = 8'hFD; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'h55; b8 = 8'h55;
    lat = 0;
    while (!ov8 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_checks++; if (p8 !== 16'hFFEB) begin n_fail++; $display("FAIL basic_product got=%h exp=ffeb", p8); end
    @(posedge clk); #1;
    n_checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      n_fail++; $display("FAIL basic_after got ov=%b ir=%b exp ov=0 ir=1", ov8, ir8);
    end
    ordy8 = 1'b0;
  endtask

  task automatic test_extremes();
    logic [15:0] g;
    run8(8'h80, 8'h80, 1'b0, g);
    n_checks++; if (g !== 16'h4000) begin n_fail++; $display("FAIL min_x_min got=%h exp=4000", g); end
    run8(8'h80, 8'h7F, 1'b0, g);
    n_checks++; if (g !== 16'hC080) begin n_fail++; $display("FAIL min_x_max got=%h exp=c080", g); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    ordy8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'hF5; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h22; b8 = 8'h33;   // keep offering a second op; it must not be taken
    wait_ov8(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout out_valid=%b exp=1", ov8); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || p8 !== 16'hFF9D) begin
        n_fail++;
        $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b p=%h exp ov=1 ir=0 p=ff9d", i, ov8, ir8, p8);
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    base = hs8;
    ordy8 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (hs8 - base != 1) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=1", hs8 - base); end
    ordy8 = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] g;
    bit rose;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd6; b8 = 8'd7; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    ab8 = 1'b1;
    @(posedge clk); #1;
    ab8 = 1'b0;
    n_checks++;
    if (bz8 !== 1'b0 || ir8 !== 1'b1 || ov8 !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got bz=%b ir=%b ov=%b exp bz=0 ir=1 ov=0", bz8, ir8, ov8);
    end
    n_checks++; if (q8.size() != 1) begin n_fail++; $display("FAIL abort_pending got=%0d exp=1", q8.size()); end
    q8.delete();
    rose = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (ov8) rose = 1'b1; end
    n_checks++; if (rose) begin n_fail++; $display("FAIL abort_no_output got=%b exp=0", rose); end
    ordy8 = 1'b0;
    run8(8'd6, 8'hFA, 1'b1, g);   // abort raised with in_valid in IDLE
    n_checks++; if (g !== 16'hFFDC) begin n_fail++; $display("FAIL abort_next got=%h exp=ffdc", g); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] g;
    bit rose;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd100; b8 = 8'd100; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov8 !== 1'b0 || bz8 !== 1'b0 || ir8 !== 1'b0 || p8 !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset got ov=%b bz=%b ir=%b p=%h exp ov=0 bz=0 ir=0 p=0000", ov8, bz8, ir8, p8);
    end
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rose = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ov8) rose = 1'b1; end
    n_checks++; if (rose) begin n_fail++; $display("FAIL midreset_no_output got=%b exp=0", rose); end
    ordy8 = 1'b0;
    run8(8'd0, 8'hFB, 1'b0, g);
    n_checks++; if (g !== 16'h0) begin n_fail++; $display("FAIL midreset_next got=%h exp=0000", g); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    logic [63:0] pe[3];
    int acc_cyc[$];
    int idx, guard;
    logic acc;
    pa = '{32'd3, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    pb = '{32'd5, 32'hFFFF_FFFF, 32'd2};
    pe = '{64'd15, 64'd1, 64'h0000_0000_FFFF_FFFE};
    got32.delete();
    ordy32 = 1'b1;
    @(posedge clk); #1;
    idx = 0; a32 = pa[0]; b32 = pb[0]; iv32 = 1'b1;
    guard = 0;
    while (idx < 3 && guard < 200) begin
      @(negedge clk); acc = iv32 && ir32;
      @(posedge clk); #1; guard++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) begin a32 = pa[idx]; b32 = pb[idx]; end
        else iv32 = 1'b0;
      end
    end
    guard = 0;
    while (got32.size() < 3 && guard < 60) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (got32.size() != 3 || acc_cyc.size() != 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d/%0d exp=3/3", got32.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got32[i] !== pe[i]) begin n_fail++; $display("FAIL b2b_product%0d got=%h exp=%h", i, got32[i], pe[i]); end
      end
      // 16 RUN edges, then the DONE edge that hands off and accepts together
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 17) begin
          n_fail++; $display("FAIL b2b_interval%0d got=%0d exp=17", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    ordy32 = 1'b0;
  endtask

  task automatic rand8();
    logic acc;
    int sent = 0, g = 0;
    iv8 = 1'b0; ordy8 = 1'b1;
    while (sent < 25 && g < 3000) begin
      @(negedge clk); acc = iv8 && ir8;
      @(posedge clk); #1; g++;
      if (acc) sent++;
      ordy8 = ($urandom_range(0, 3) != 0);
      if (acc || !iv8) begin
        iv8 = (sent < 25) && ($urandom_range(0, 2) != 0);
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    g = 0;
    while (q8.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    n_checks++; if (q8.size() != 0 || sent != 25) begin n_fail++; $display("FAIL rand8_drain got left=%0d sent=%0d exp left=0 sent=25", q8.size(), sent); end
  endtask

  task automatic rand16();
    logic acc;
    int sent = 0, g = 0;
    iv16 = 1'b0; ordy16 = 1'b1;
    while (sent < 25 && g < 3000) begin
      @(negedge clk); acc = iv16 && ir16;
      @(posedge clk); #1; g++;
      if (acc) sent++;
      ordy16 = ($urandom_range(0, 3) != 0);
      if (acc || !iv16) begin
        iv16 = (sent < 25) && ($urandom_range(0, 2) != 0);
        a16 = pick16(); b16 = pick16();
      end
    end
    iv16 = 1'b0; ordy16 = 1'b1;
    g = 0;
    while (q16.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    n_checks++; if (q16.size() != 0 || sent != 25) begin n_fail++; $display("FAIL rand16_drain got left=%0d sent=%0d exp left=0 sent=25", q16.size(), sent); end
  endtask

  task automatic rand32();
    logic acc;
    int sent = 0, g = 0;
    iv32 = 1'b0; ordy32 = 1'b1;
    while (sent < 25 && g < 3000) begin
      @(negedge clk); acc = iv32 && ir32;
      @(posedge clk); #1; g++;
      if (acc) sent++;
      ordy32 = ($urandom_range(0, 3) != 0);
      if (acc || !iv32) begin
        iv32 = (sent < 25) && ($urandom_range(0, 2) != 0);
        a32 = pick32(); b32 = pick32();
      end
    end
    iv32 = 1'b0; ordy32 = 1'b1;
    g = 0;
    while (q32.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    n_checks++; if (q32.size() != 0 || sent != 25) begin n_fail++; $display("FAIL rand32_drain got left=%0d sent=%0d exp left=0 sent=25", q32.size(), sent); end
  endtask

  task automatic test_random();
    fork
      rand8();
      rand16();
      rand32();
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1);
  end

endmodule
